// File: rtl/ev_multi_motor_ctrl.sv
// ev_multi_motor_ctrl: NCH-channel motor controller with slew-limited speed ramps, PWM, thermal derating
// Ports: clk, rst (sync, active high); en system power; cmd_valid/cmd_ready/cmd_ch/cmd_accel/cmd_brake
//   command handshake; cmd_err bad-channel pulse; pwm_out, speed_out, at_target, overheat per channel.
module ev_multi_motor_ctrl #(
  parameter int NCH       = 2,
  parameter int CMD_W     = 4,
  parameter int DUTY_W    = 8,
  parameter int SCALE_SH  = 4,
  parameter int RAMP_DIV  = 16,
  parameter int RAMP_STEP = 4,
  parameter int TEMP_W    = 7,
  parameter int T_AMB     = 25,
  parameter int T_TRIP    = 85,
  parameter int T_CLEAR   = 75,
  parameter int T_LOAD    = 50,
  parameter int T_DIV     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_ch,
  input  logic [CMD_W-1:0]         cmd_accel,
  input  logic [CMD_W-1:0]         cmd_brake,
  output logic                     cmd_err,
  output logic [NCH-1:0]           pwm_out,
  output logic [NCH*DUTY_W-1:0]    speed_out,
  output logic [NCH-1:0]           at_target,
  output logic [NCH-1:0]           overheat
);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int TW = $clog2(T_DIV + 1);
  localparam logic [DUTY_W-1:0] DMAX  = '1;
  localparam logic [DUTY_W-1:0] PMAX  = DMAX - 1'b1;
  localparam logic [DUTY_W-1:0] STEP  = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] LOAD  = DUTY_W'(T_LOAD);
  localparam logic [TEMP_W-1:0] TMAX  = '1;
  localparam logic [TEMP_W-1:0] TAMB  = TEMP_W'(T_AMB);
  localparam logic [TEMP_W-1:0] TTRIP = TEMP_W'(T_TRIP);
  localparam logic [TEMP_W-1:0] TCLR  = TEMP_W'(T_CLEAR);
  localparam logic [RW-1:0]     RLAST = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0]     TLAST = TW'(T_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DERATE} state_e;

  state_e              state_q  [NCH];
  state_e              state_d  [NCH];
  logic [DUTY_W-1:0]   target_q [NCH];
  logic [DUTY_W-1:0]   target_d [NCH];
  logic [DUTY_W-1:0]   speed_q  [NCH];
  logic [DUTY_W-1:0]   speed_d  [NCH];
  logic [DUTY_W-1:0]   duty_q   [NCH];
  logic [DUTY_W-1:0]   duty_d   [NCH];
  logic [TEMP_W-1:0]   temp_q   [NCH];
  logic [TEMP_W-1:0]   temp_d   [NCH];
  logic [DUTY_W-1:0]   eff      [NCH];
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DUTY_W-1:0]   pcnt_q, pcnt_d;
  logic                cmd_err_q, cmd_err_d;
  logic                acc, rtick, ttick;
  logic [DUTY_W:0]     raw_w;
  logic [DUTY_W-1:0]   raw;

  function automatic logic [DUTY_W-1:0] ramp_f(input logic [DUTY_W-1:0] s, input logic [DUTY_W-1:0] e);
    return e > s ? (e - s > STEP ? s + STEP : e) : (s - e > STEP ? s - STEP : e);
  endfunction

  assign cmd_ready = en & ~rst;
  assign cmd_err   = cmd_err_q;

  always_comb begin
    acc       = cmd_valid & cmd_ready;
    rtick     = rcnt_q == RLAST;
    ttick     = tcnt_q == TLAST;
    rcnt_d    = rtick ? '0 : rcnt_q + 1'b1;
    tcnt_d    = ttick ? '0 : tcnt_q + 1'b1;
    pcnt_d    = pcnt_q == PMAX ? '0 : pcnt_q + 1'b1;
    cmd_err_d = acc && ({1'b0, cmd_ch} >= 4'(NCH));
    raw_w     = cmd_accel > cmd_brake ? (DUTY_W+1)'(cmd_accel - cmd_brake) << SCALE_SH : '0;
    raw       = raw_w[DUTY_W] ? DMAX : raw_w[DUTY_W-1:0];
    state_d   = state_q;
    target_d  = target_q;
    speed_d   = speed_q;
    duty_d    = duty_q;
    temp_d    = temp_q;
    eff       = target_q;
    pwm_out   = '0;
    speed_out = '0;
    at_target = '0;
    overheat  = '0;
    for (int k = 0; k < NCH; k++) begin
      eff[k]      = state_q[k] == DERATE ? target_q[k] >> 1 : target_q[k];
      state_d[k]  = !en ? IDLE :
                    state_q[k] == IDLE ? RUN :
                    (state_q[k] == RUN && temp_q[k] >= TTRIP) ? DERATE :
                    (state_q[k] == DERATE && temp_q[k] <= TCLR) ? RUN : state_q[k];
      target_d[k] = !en ? '0 : (acc && cmd_ch == 3'(k)) ? raw : target_q[k];
      speed_d[k]  = !en ? '0 : rtick ? ramp_f(speed_q[k], eff[k]) : speed_q[k];
      // Duty is loaded on the wrap so a whole period (counter 0..PMAX) uses one value
      duty_d[k]   = pcnt_q == PMAX ? speed_q[k] : duty_q[k];
      temp_d[k]   = !ttick ? temp_q[k] :
                    speed_q[k] > LOAD ? (temp_q[k] == TMAX ? temp_q[k] : temp_q[k] + 1'b1) :
                    temp_q[k] > TAMB ? temp_q[k] - 1'b1 : temp_q[k];
      pwm_out[k]  = state_q[k] != IDLE && pcnt_q < duty_q[k];
      at_target[k] = state_q[k] != IDLE && speed_q[k] == eff[k];
      overheat[k] = state_q[k] == DERATE;
      speed_out[k*DUTY_W +: DUTY_W] = speed_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      pcnt_q    <= '0;
      cmd_err_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= IDLE;
        target_q[k] <= '0;
        speed_q[k]  <= '0;
        duty_q[k]   <= '0;
        temp_q[k]   <= TAMB;
      end
    end else begin
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      cmd_err_q <= cmd_err_d;
      state_q   <= state_d;
      target_q  <= target_d;
      speed_q   <= speed_d;
      duty_q    <= duty_d;
      temp_q    <= temp_d;
    end
  end
endmodule

// File: tb/tb_ev_multi_motor_ctrl.sv
// tb_ev_multi_motor_ctrl: directed checks of ramp, PWM, thermal derating, command errors and reset
module tb_ev_multi_motor_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_ch = '0;
  logic [3:0]  cmd_accel = '0;
  logic [3:0]  cmd_brake = '0;
  logic        cmd_ready, cmd_err;
  logic [1:0]  pwm_out, at_target, overheat;
  logic [15:0] speed_out;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ev_multi_motor_ctrl #(.T_DIV(64)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_accel(cmd_accel), .cmd_brake(cmd_brake), .cmd_err(cmd_err),
    .pwm_out(pwm_out), .speed_out(speed_out), .at_target(at_target), .overheat(overheat)
  );

  function automatic int sp(input int ch);
    return int'(speed_out[ch*8 +: 8]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int ch, input int a, input int b);
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_accel = 4'(a);
    cmd_brake = 4'(b);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic ramp_to(input int ch, input int val, input int lim, output int steps);
    int cyc = 0;
    int last = -1;
    int prev = sp(ch);
    steps = 0;
    while (sp(ch) != val && cyc < lim) begin
      step(1);
      cyc++;
      if (sp(ch) != prev) begin
        chk("ramp_step", sp(ch) > prev ? sp(ch) - prev : prev - sp(ch), 4);
        if (last >= 0) chk("ramp_interval", cyc - last, 16);
        last = cyc;
        prev = sp(ch);
        steps++;
      end
    end
    chk("ramp_reach", sp(ch), val);
  endtask

  initial begin
    int s, cnt, hi, lo1, late, prev;
    step(3);
    chk("rst_speed", speed_out, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_at_target", at_target, 0);
    chk("rst_overheat", overheat, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_err", cmd_err, 0);
    rst = 1'b0;
    en  = 1'b1;
    #1;
    chk("ready_en", cmd_ready, 1);
    step(1);
    chk("run_at_target", at_target, 3);
    chk("run_overheat", overheat, 0);

    send(0, 9, 2);
    chk("t2_not_at_target", at_target[0], 0);
    ramp_to(0, 112, 600, s);
    chk("t2_steps", s, 28);
    chk("t2_at_target", at_target, 3);
    chk("t2_ch1_idle", sp(1), 0);

    send(0, 15, 0);
    ramp_to(0, 240, 700, s);
    chk("t3_up_steps", s, 32);
    send(0, 3, 7);
    ramp_to(0, 0, 1200, s);
    chk("t3_down_steps", s, 60);
    chk("t3_at_target", at_target[0], 1);

    send(0, 4, 0);
    ramp_to(0, 64, 400, s);
    chk("t4_ramp_steps", s, 16);
    step(300);
    cnt  = 0;
    prev = pwm_out[0];
    while (!(pwm_out[0] && !prev) && cnt < 600) begin
      prev = pwm_out[0];
      step(1);
      cnt++;
    end
    chk("t4_sync", int'(cnt < 600), 1);
    hi  = 0;
    lo1 = 0;
    for (int i = 0; i < 255; i++) begin
      hi  += pwm_out[0];
      lo1 += pwm_out[1];
      step(1);
    end
    chk("t4_high_clks", hi, 64);
    chk("t4_duty0_low", lo1, 0);
    hi   = 0;
    late = 0;
    for (int i = 0; i < 255; i++) begin
      hi += pwm_out[0];
      if (i >= 64) late += pwm_out[0];
      if (i == 100) begin
        cmd_valid = 1'b1;
        cmd_ch    = 3'd0;
        cmd_accel = 4'd8;
        cmd_brake = 4'd0;
      end
      if (i == 101) cmd_valid = 1'b0;
      step(1);
    end
    chk("t4_mid_change_high", hi, 64);
    chk("t4_mid_change_late", late, 0);
    chk("t4_speed_moved", int'(sp(0) > 64), 1);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      hi += pwm_out[0];
      step(1);
    end
    chk("t4_next_period", int'(hi > 64 && hi <= 128), 1);
    send(0, 0, 0);
    ramp_to(0, 0, 1000, s);

    send(1, 13, 0);
    ramp_to(1, 208, 1000, s);
    chk("t5_ramp_steps", s, 52);
    chk("t5_cool_before", overheat, 0);
    cnt = 0;
    while (!overheat[1] && cnt < 8000) begin
      step(1);
      cnt++;
    end
    chk("t5_trip", overheat, 2);
    chk("t5_trip_not_at_target", at_target[1], 0);
    ramp_to(1, 104, 600, s);
    chk("t5_derate_steps", s, 26);
    chk("t5_derate_at_target", at_target, 3);
    send(1, 0, 0);
    step(500);
    chk("t5_hysteresis", overheat, 2);
    chk("t5_speed_zero", sp(1), 0);
    cnt = 0;
    while (overheat[1] && cnt < 3000) begin
      step(1);
      cnt++;
    end
    chk("t5_clear", overheat, 0);

    send(5, 15, 0);
    chk("t6_err_pulse", cmd_err, 1);
    step(1);
    chk("t6_err_done", cmd_err, 0);
    chk("t6_no_speed", speed_out, 0);
    chk("t6_at_target", at_target, 3);
    send(0, 8, 0);
    cnt = 0;
    while (sp(0) < 20 && cnt < 200) begin
      step(1);
      cnt++;
    end
    chk("t6_mid_ramp", int'(sp(0) >= 20 && sp(0) < 128), 1);
    en = 1'b0;
    #1;
    chk("t6_ready_off", cmd_ready, 0);
    step(1);
    chk("t6_off_speed", speed_out, 0);
    chk("t6_off_pwm", pwm_out, 0);
    chk("t6_off_at_target", at_target, 0);
    cmd_valid = 1'b1;
    cmd_ch    = 3'd0;
    cmd_accel = 4'd15;
    step(1);
    cmd_valid = 1'b0;
    chk("t6_ignored_no_err", cmd_err, 0);
    en = 1'b1;
    step(40);
    chk("t6_ignored_speed", sp(0), 0);
    chk("t6_back_at_target", at_target, 3);

    send(0, 8, 0);
    cnt = 0;
    while (sp(0) < 8 && cnt < 200) begin
      step(1);
      cnt++;
    end
    rst = 1'b1;
    step(3);
    chk("t1_rst_speed", speed_out, 0);
    chk("t1_rst_pwm", pwm_out, 0);
    chk("t1_rst_at_target", at_target, 0);
    chk("t1_rst_overheat", overheat, 0);
    chk("t1_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("t1_ready_back", cmd_ready, 1);
    step(40);
    chk("t1_target_cleared", speed_out, 0);
    chk("t1_at_target", at_target, 3);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end
endmodule
